// File: rtl/cpu8_seq_ctrl_if.sv
// cpu8_seq_ctrl_if: bus bundle between the cpu8 sequencer and its environment.
//   en        run enable into the sequencer
//   rom_addr  program ROM address (sequencer drives it; it always equals pc)
//   rom_data  combinational ROM read data for rom_addr
//   pc        current program counter
//   r0..r3    register file contents
//   flag_z    zero flag
//   flag_c    carry/borrow flag
//   halted    high while the sequencer sits in HALT
// master: the sequencer side. slave: the ROM / observer side.
interface cpu8_seq_ctrl_if;
  logic        en;
  logic [7:0]  rom_addr;
  logic [15:0] rom_data;
  logic [7:0]  pc;
  logic [7:0]  r0;
  logic [7:0]  r1;
  logic [7:0]  r2;
  logic [7:0]  r3;
  logic        flag_z;
  logic        flag_c;
  logic        halted;

  modport master (
    input  en, rom_data,
    output rom_addr, pc, r0, r1, r2, r3, flag_z, flag_c, halted
  );

  modport slave (
    output en, rom_data,
    input  rom_addr, pc, r0, r1, r2, r3, flag_z, flag_c, halted
  );
endinterface

// File: rtl/cpu8_seq_ctrl.sv
// cpu8_seq_ctrl: multi-cycle fetch/execute sequencer for the 8-bit test CPU.
// Drives the program ROM address from pc, latches the instruction word in
// FETCH, executes it against a 4x8 register file and Z/C flags in EXEC, and
// parks in HALT after an HLT instruction until reset.
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset
//   bus   cpu8_seq_ctrl_if.master (en, rom_addr, rom_data, pc, r0..r3,
//         flag_z, flag_c, halted)
// Parameter:
//   RESET_PC  program counter value loaded on reset
module cpu8_seq_ctrl #(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic             clk,
  input  logic             rst,
  cpu8_seq_ctrl_if.master  bus
);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  typedef enum logic [3:0] {
    OP_EXT  = 4'h0,
    OP_MOVI = 4'h1,
    OP_MOVR = 4'h2,
    OP_ADDI = 4'h3,
    OP_JMP  = 4'h4,
    OP_JZ   = 4'h5,
    OP_JNZ  = 4'h6,
    OP_ADDR = 4'h7,
    OP_SUBR = 4'h8,
    OP_ANDR = 4'h9,
    OP_ORR  = 4'hA,
    OP_XORR = 4'hB,
    OP_CMPR = 4'hC,
    OP_CMPI = 4'hD,
    OP_SUBI = 4'hE,
    OP_HLT  = 4'hF
  } op_t;

  state_t      state_q, state_d;
  logic [7:0]  pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic [7:0]  rf_q [4];
  logic [7:0]  rf_d [4];
  logic        z_q, z_d;
  logic        c_q, c_d;

  // Decoded fields and datapath results
  op_t         op;
  logic [1:0]  rd;
  logic [1:0]  rs;
  logic [7:0]  imm;
  logic [3:0]  sub;
  logic [3:0]  sh;
  logic [7:0]  opa;
  logic [7:0]  opb;
  logic [8:0]  sum;
  logic [8:0]  diff;
  logic [7:0]  shl;
  logic [7:0]  shr;
  logic [7:0]  pc_inc;

  // Operands come from the current register file, so rd == rs reads the
  // old value before the write-back in the same EXEC.
  always_comb begin
    op     = op_t'(ir_q[15:12]);
    rd     = ir_q[11:10];
    rs     = ir_q[9:8];
    imm    = ir_q[7:0];
    sub    = imm[7:4];
    sh     = imm[3:0];
    opa    = rf_q[rd];
    opb    = ((op == OP_ADDI) || (op == OP_CMPI) || (op == OP_SUBI)) ? imm : rf_q[rs];
    sum    = {1'b0, opa} + {1'b0, opb};
    // Bit 8 of the zero-extended difference is the borrow (opa < opb).
    diff   = {1'b0, opa} - {1'b0, opb};
    shl    = sh[3] ? '0 : (opa << sh[2:0]);
    shr    = sh[3] ? '0 : (opa >> sh[2:0]);
    pc_inc = pc_q + 8'd1;
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    rf_d    = rf_q;
    z_d     = z_q;
    c_d     = c_q;

    if (bus.en) begin
      unique case (state_q)
        ST_FETCH: begin
          ir_d    = bus.rom_data;
          state_d = ST_EXEC;
        end

        ST_EXEC: begin
          pc_d    = pc_inc;
          state_d = ST_FETCH;
          unique case (op)
            OP_EXT: begin
              if (sub == 4'd1) begin
                rf_d[rd] = shl;
                z_d      = (shl == 8'd0);
              end else if (sub == 4'd2) begin
                rf_d[rd] = shr;
                z_d      = (shr == 8'd0);
              end
            end
            OP_MOVI: rf_d[rd] = imm;
            OP_MOVR: rf_d[rd] = opb;
            OP_ADDI, OP_ADDR: begin
              rf_d[rd] = sum[7:0];
              z_d      = (sum[7:0] == 8'd0);
              c_d      = sum[8];
            end
            OP_JMP: pc_d = imm;
            OP_JZ: begin
              if (z_q) pc_d = imm;
            end
            OP_JNZ: begin
              if (!z_q) pc_d = imm;
            end
            OP_SUBR, OP_SUBI: begin
              rf_d[rd] = diff[7:0];
              z_d      = (diff[7:0] == 8'd0);
              c_d      = diff[8];
            end
            OP_ANDR: begin
              rf_d[rd] = opa & opb;
              z_d      = ((opa & opb) == 8'd0);
              c_d      = 1'b0;
            end
            OP_ORR: begin
              rf_d[rd] = opa | opb;
              z_d      = ((opa | opb) == 8'd0);
              c_d      = 1'b0;
            end
            OP_XORR: begin
              rf_d[rd] = opa ^ opb;
              z_d      = ((opa ^ opb) == 8'd0);
              c_d      = 1'b0;
            end
            OP_CMPR, OP_CMPI: begin
              z_d = (diff[7:0] == 8'd0);
              c_d = diff[8];
            end
            OP_HLT: begin
              pc_d    = pc_q;
              state_d = ST_HALT;
            end
            default: ;
          endcase
        end

        ST_HALT: ;

        default: state_d = ST_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      for (int unsigned i = 0; i < 4; i++) begin
        rf_q[i] <= '0;
      end
      z_q     <= 1'b0;
      c_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      rf_q    <= rf_d;
      z_q     <= z_d;
      c_q     <= c_d;
    end
  end

  assign bus.rom_addr = pc_q;
  assign bus.pc       = pc_q;
  assign bus.r0       = rf_q[0];
  assign bus.r1       = rf_q[1];
  assign bus.r2       = rf_q[2];
  assign bus.r3       = rf_q[3];
  assign bus.flag_z   = z_q;
  assign bus.flag_c   = c_q;
  assign bus.halted   = (state_q == ST_HALT);

endmodule

// File: doc/cpu8_seq_ctrl.md
# cpu8_seq_ctrl

Multi-cycle fetch/execute sequencer for the 8-bit test CPU. It drives the address of the 256x16 combinational program ROM and latches the returned instruction word. It executes the instruction against a 4x8-bit register file and Z/C flags, then advances or redirects the program counter until it reaches HLT. It is the only master of the program ROM and owns all architectural state.

## Interface
Parameters:
- RESET_PC, 8'h00, program counter value loaded on reset.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  run enable; when 0 all state holds, including the FSM.
- rom_addr  out  8  program ROM address; equals pc.
- rom_data  in  16  combinational ROM read data for rom_addr.
- pc  out  8  current program counter.
- r0, r1, r2, r3  out  8 each  register file contents.
- flag_z, flag_c  out  1 each  zero and carry/borrow flags.
- halted  out  1  high while in HALT.

## Operation
- Instruction fields: [15:12] opcode, [11:10] rd, [9:8] rs, [7:0] imm.
- FSM states:
  - FETCH: ir <= rom_data; goto EXEC.
  - EXEC: perform the operation and update pc; goto FETCH, or goto HALT on HLT.
  - HALT: terminal state; left only by rst.
- Default pc update in EXEC is pc+1, mod 256: 8'hFF wraps to 8'h00.
- Arithmetic is 8-bit.
  - Add: C = carry out of bit 7.
  - Sub/compare: C = borrow, i.e. a < b unsigned.
  - Z = (8-bit result == 0).
- Opcodes:
  - 0 EXT: sub = imm[7:4], sh = imm[3:0].
    - sub 1 SHLI: rd <<= sh.
    - sub 2 SHRI: rd >>= sh (logical).
    - sh >= 8 yields 0.
    - Z updated, C unchanged.
    - Other sub values are NOP; no flag change.
  - 1 MOVI: rd = imm; flags unchanged.
  - 2 MOVR: rd = rs; flags unchanged.
  - 3 ADDI: rd = rd+imm; Z, C.
  - 4 JMP: pc = imm.
  - 5 JZ: pc = Z ? imm : pc+1.
  - 6 JNZ: pc = Z ? pc+1 : imm.
  - 7 ADDR: rd = rd+rs; Z, C.
  - 8 SUBR: rd = rd-rs; Z, C.
  - 9 ANDR, A ORR, B XORR: rd = rd op rs; Z updated, C = 0.
  - C CMPR: flags from rd-rs; no register write.
  - D CMPI: flags from rd-imm; no register write.
  - E SUBI: rd = rd-imm; Z, C.
  - F HLT: pc unchanged; goto HALT.
- rd == rs is legal. Source operands are read before the write, e.g. SUBR R1,R1 gives 0 with Z=1, C=0.
- A jump target may equal its own address; the resulting infinite loop is legal.

## Timing
- Reset values, applied asynchronously on rst:
  - pc = RESET_PC, ir = 0, r0..r3 = 0.
  - flag_z = 0, flag_c = 0, halted = 0, state = FETCH.
- rst asserted mid-instruction aborts it; no partial register write survives.
- rom_addr = pc is combinational from the pc register. ROM data is sampled at the end of FETCH.
- Each instruction takes 2 enabled cycles (FETCH, EXEC).
- Register, flag and pc updates are visible on outputs the cycle after EXEC.
- halted rises the cycle after HLT's EXEC. pc then stays at the HLT address.
- en = 0 freezes state, pc, ir, registers and flags. The instruction resumes exactly where it stopped when en returns to 1. en is a don't-care in HALT.
- If en deasserts during EXEC, that EXEC does not take effect until en returns high.

## Test plan
- Basic program, en held 1:
  - Program: 00:1005, 01:1407, 02:1801, 03:0811, 04:0821, 05:7100, 06:C100, 07:500A, 08:E00C, 09:500C, 0A:1455, 0B:400C, 0C:F000.
  - Required: halted rises 22 cycles after reset release; r0=0, r1=7, r2=1, r3=0, Z=1, C=0, pc=0C.
- Carry/borrow:
  - MOVI R0,FF; ADDI R0,01 -> r0=00, Z=1, C=1.
  - Then SUBI R0,01 -> r0=FF, Z=0, C=1.
- Shift bounds: MOVI R3,81; SHLI R3,8 -> r3=00, Z=1.
- PC wrap: MOVI at FF, HLT at 00, with RESET_PC=FF -> executes FF then 00; halted with pc=00.
- Stall: toggle en 0/1 every 3 cycles on the basic program -> identical final state; halted rises only after 22 enabled cycles.
- Reset mid-run: assert rst during EXEC of ADDR -> all outputs return to reset values immediately; the rerun completes normally.
